// File: rtl/seven_seg_display.sv
// seven_seg_display: time-multiplexed driver for a 4-digit common-anode
// 7-segment display with one decimal point per digit.
// Latency: outputs are registered, one clk after the counter and inputs are sampled.
// Backpressure: none; the scan free-runs and the inputs are sampled every cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset (blanks the display, restarts the scan)
//   display_N  digit N code, [3:0] hex value, [7:4] ignored (N=0 is rightmost)
//   decplace   index of the digit whose decimal point is lit
//   seg        active-low segments {dp,g,f,e,d,c,b,a}
//   an         active-low digit enables, at most one bit low
module seven_seg_display #(
  parameter int CNT_W = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] display_0,
  input  logic [7:0] display_1,
  input  logic [7:0] display_2,
  input  logic [7:0] display_3,
  input  logic [1:0] decplace,
  output logic [7:0] seg,
  output logic [3:0] an
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic [1:0]       idx;
  logic [3:0]       nib;
  logic [6:0]       hex;

  always_comb begin
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    // The top two counter bits pick the digit, so each digit is held for
    // 2^(CNT_W-2) cycles and the scan moves on with no blank gap.
    idx   = cnt_q[CNT_W-1 -: 2];

    nib = display_0[3:0];
    case (idx)
      2'd0:    nib = display_0[3:0];
      2'd1:    nib = display_1[3:0];
      2'd2:    nib = display_2[3:0];
      default: nib = display_3[3:0];
    endcase

    // Active-high gfedcba pattern.
    hex = 7'h00;
    case (nib)
      4'h0: hex = 7'h3F;
      4'h1: hex = 7'h06;
      4'h2: hex = 7'h5B;
      4'h3: hex = 7'h4F;
      4'h4: hex = 7'h66;
      4'h5: hex = 7'h6D;
      4'h6: hex = 7'h7D;
      4'h7: hex = 7'h07;
      4'h8: hex = 7'h7F;
      4'h9: hex = 7'h6F;
      4'hA: hex = 7'h77;
      4'hB: hex = 7'h7C;
      4'hC: hex = 7'h39;
      4'hD: hex = 7'h5E;
      4'hE: hex = 7'h79;
      default: hex = 7'h71;
    endcase

    an_d  = ~(4'b0001 << idx);
    seg_d = ~{(decplace == idx), hex};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      seg_q <= 8'hFF;
      an_q  <= 4'hF;
    end else begin
      cnt_q <= cnt_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_display.sv
module tb_seven_seg_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] display_0 = 8'h00;
  logic [7:0] display_1 = 8'h01;
  logic [7:0] display_2 = 8'h02;
  logic [7:0] display_3 = 8'h03;
  logic [1:0] decplace = 2'd2;
  logic [7:0] seg;
  logic [3:0] an;

  int tests = 0;
  int errs  = 0;
  int tb_cnt = 0;  // bench's own copy of the 4-bit refresh counter

  // Active-low seg values (dp off) for hex digits 0..F, computed by hand.
  logic [7:0] seg_nodp [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  // Scan pattern for display_0..3 = 0,1,2,3 with decplace=2.
  logic [7:0] frame_seg [4] = '{8'hC0, 8'hF9, 8'h24, 8'hB0};
  logic [3:0] frame_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  seven_seg_display #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .display_0(display_0), .display_1(display_1),
    .display_2(display_2), .display_3(display_3),
    .decplace(decplace), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst) tb_cnt = 0;
    else tb_cnt = (tb_cnt + 1) % 16;
    #1;
  endtask

  // Advance until the next edge will drive digit d.
  task automatic go_to_digit(input int d);
    for (int i = 0; i < 16 && (tb_cnt / 4) != d; i++) tick();
  endtask

  initial begin
    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_seg", seg, 8'hFF);
      check_val("rst_an", {4'h0, an}, 8'h0F);
    end
    rst = 1'b0;

    // Three full frames: digit k/4 shown on tick k, pattern repeating.
    for (int k = 0; k < 48; k++) begin
      tick();
      check_val($sformatf("scan_an_%0d", k), {4'h0, an}, {4'h0, frame_an[(k / 4) % 4]});
      check_val($sformatf("scan_seg_%0d", k), seg, frame_seg[(k / 4) % 4]);
      check_val($sformatf("onehot_%0d", k), 8'($countones(~an)), 8'd1);
    end

    // Upper nibble ignored: FA shows as A.
    go_to_digit(0);
    display_0 = 8'hFA;
    tick();
    check_val("upper_nib_an", {4'h0, an}, 8'h0E);
    check_val("upper_nib_seg", seg, 8'h88);

    // Hex sweep on digit 0 with its decimal point lit.
    decplace = 2'd0;
    for (int v = 0; v < 16; v++) begin
      go_to_digit(0);
      display_0 = 8'(v);
      tick();
      check_val($sformatf("hex_an_%0h", v), {4'h0, an}, 8'h0E);
      check_val($sformatf("hex_seg_%0h", v), seg, seg_nodp[v] & 8'h7F);
    end
    check_val("hex_F_seg", seg, 8'h0E);

    // Reset in the middle of digit 2.
    display_0 = 8'h00;
    decplace = 2'd2;
    go_to_digit(2);
    tick();
    check_val("mid_pre_an", {4'h0, an}, 8'h0B);
    check_val("mid_pre_seg", seg, 8'h24);
    rst = 1'b1;
    tick();
    check_val("mid_rst_seg", seg, 8'hFF);
    check_val("mid_rst_an", {4'h0, an}, 8'h0F);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_val($sformatf("restart_an_%0d", k), {4'h0, an}, {4'h0, frame_an[k / 4]});
      check_val($sformatf("restart_seg_%0d", k), seg, frame_seg[k / 4]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
